sram_like_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the sram-like bus.
- Merges the instruction-side and data-side sram-like ports from the CPU core (outputs of the inst/data sram-like bridges) onto a single sram-like port toward the AXI bridge or memory.
- One outstanding transaction at a time. Request fields are latched at grant. Responses are routed back to the owning master.

---
 rtl/sram_like_arbiter_if.sv | 24 ++
 rtl/sram_like_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_if.sv
// One sram-like port: request fields flow master->slave, handshake and read data flow back.
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave sram-like arbiter, one transaction in flight.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: alternate grants when both masters request.
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  sram_like_arbiter_if.slave     inst_if,
  sram_like_arbiter_if.slave     data_if,
  sram_like_arbiter_if.master    m_if,
  output logic                   owner_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic any_req;
  logic pick_data;
  logic addr_hit;
  logic data_hit;

  assign any_req = inst_if.req | data_if.req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On contention the master that did not win last time gets the bus.
  assign pick_data = (inst_if.req & data_if.req) ? ~last_q : data_if.req;
  assign last_d    = (state_q == IDLE && any_req) ? pick_data : last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick_data = data_if.req;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    addr_hit = 1'b0;
    data_hit = 1'b0;
    case (state_q)
      IDLE: begin
        // Slave handshakes seen here are strays and never reach a master.
        if (any_req) begin
          owner_d = pick_data;
          wr_d    = pick_data ? data_if.wr    : inst_if.wr;
          size_d  = pick_data ? data_if.size  : inst_if.size;
          addr_d  = pick_data ? data_if.addr  : inst_if.addr;
          wdata_d = pick_data ? data_if.wdata : inst_if.wdata;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_if.addr_ok) begin
          addr_hit = 1'b1;
          state_d  = DATA;
          if (m_if.data_ok) begin
            data_hit = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DATA: begin
        if (m_if.data_ok) begin
          data_hit = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_if.req   = (state_q == ADDR);
  assign m_if.wr    = wr_q;
  assign m_if.size  = size_q;
  assign m_if.addr  = addr_q;
  assign m_if.wdata = wdata_q;

  assign inst_if.addr_ok = addr_hit & ~owner_q;
  assign data_if.addr_ok = addr_hit &  owner_q;
  assign inst_if.data_ok = data_hit & ~owner_q;
  assign data_if.data_ok = data_hit &  owner_q;
  assign inst_if.rdata   = (data_hit & ~owner_q) ? m_if.rdata : '0;
  assign data_if.rdata   = (data_hit &  owner_q) ? m_if.rdata : '0;

  assign owner_o = owner_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_sram_like_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) inst_bus ();
  sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) data_bus ();
  sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();
  logic owner;
  logic busy;

  sram_like_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .inst_if (inst_bus),
    .data_if (data_bus),
    .m_if    (mem_bus),
    .owner_o (owner),
    .busy_o  (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending transaction, with or without its address accepted.
  bit          have = 1'b0;
  bit          adone = 1'b0;
  bit          own = 1'b0;
  logic        wr_e = 1'b0;
  logic [1:0]  size_e = 2'd0;
  logic [31:0] addr_e = 32'd0;
  logic [31:0] wdata_e = 32'd0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  bit          last_m = 1'b0;
`endif

  always @(negedge clk) begin : compare
    bit w;
    bit ex_aok;
    bit ex_dok;
    if (!rst_ni) begin
      have = 1'b0; adone = 1'b0; own = 1'b0;
      wr_e = 1'b0; size_e = 2'd0; addr_e = 32'd0; wdata_e = 32'd0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_m = 1'b0;
`endif
    end
    ex_aok = have && !adone && (mem_bus.addr_ok === 1'b1);
    ex_dok = have && (adone ? (mem_bus.data_ok === 1'b1)
                            : (mem_bus.addr_ok === 1'b1 && mem_bus.data_ok === 1'b1));
    chk1("busy", busy, have);
    chk1("m_req", mem_bus.req, have && !adone);
    chk1("owner", owner, own);
    chk1("m_wr", mem_bus.wr, wr_e);
    chk32("m_size", 32'(mem_bus.size), 32'(size_e));
    chk32("m_addr", mem_bus.addr, addr_e);
    chk32("m_wdata", mem_bus.wdata, wdata_e);
    chk1("inst_addr_ok", inst_bus.addr_ok, ex_aok && !own);
    chk1("data_addr_ok", data_bus.addr_ok, ex_aok && own);
    chk1("inst_data_ok", inst_bus.data_ok, ex_dok && !own);
    chk1("data_data_ok", data_bus.data_ok, ex_dok && own);
    chk32("inst_rdata", inst_bus.rdata, (ex_dok && !own) ? mem_bus.rdata : 32'd0);
    chk32("data_rdata", data_bus.rdata, (ex_dok && own) ? mem_bus.rdata : 32'd0);
    if (rst_ni) begin
      if (!have) begin
        if (inst_bus.req || data_bus.req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          w = (inst_bus.req && data_bus.req) ? ~last_m : data_bus.req;
          last_m = w;
`else
          w = data_bus.req;
`endif
          own = w; have = 1'b1; adone = 1'b0;
          wr_e    = w ? data_bus.wr    : inst_bus.wr;
          size_e  = w ? data_bus.size  : inst_bus.size;
          addr_e  = w ? data_bus.addr  : inst_bus.addr;
          wdata_e = w ? data_bus.wdata : inst_bus.wdata;
        end
      end else if (!adone) begin
        if (mem_bus.addr_ok) begin
          adone = 1'b1;
          if (mem_bus.data_ok) have = 1'b0;
        end
      end else if (mem_bus.data_ok) begin
        have = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [3:0] exp_order;
    int         k;
    bit         seen_i;
    bit         seen_d;

    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 0; inst_bus.addr = 0; inst_bus.wdata = 0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.size = 0; data_bus.addr = 0; data_bus.wdata = 0;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_m_req", mem_bus.req, 1'b0);
    chk32("rst_m_addr", mem_bus.addr, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    cyc(); rst_ni = 1'b1;

    // Single inst read
    cyc();
    inst_bus.req = 1; inst_bus.wr = 0; inst_bus.size = 2; inst_bus.addr = 32'hBFC00000;
    @(negedge clk); chk1("t1_idle_mreq", mem_bus.req, 1'b0);
    cyc();
    @(negedge clk);
    chk1("t1_mreq", mem_bus.req, 1'b1);
    chk32("t1_maddr", mem_bus.addr, 32'hBFC00000);
    chk1("t1_mwr", mem_bus.wr, 1'b0);
    chk1("t1_owner", owner, 1'b0);
    cyc(); mem_bus.addr_ok = 1;
    @(negedge clk);
    chk1("t1_inst_aok", inst_bus.addr_ok, 1'b1);
    chk1("t1_data_aok", data_bus.addr_ok, 1'b0);
    cyc(); mem_bus.addr_ok = 0; inst_bus.req = 0;
    @(negedge clk);
    chk1("t1_aok_pulse", inst_bus.addr_ok, 1'b0);
    chk1("t1_data_mreq", mem_bus.req, 1'b0);
    cyc(); mem_bus.data_ok = 1; mem_bus.rdata = 32'h3C08BFAF;
    @(negedge clk);
    chk1("t1_inst_dok", inst_bus.data_ok, 1'b1);
    chk32("t1_inst_rdata", inst_bus.rdata, 32'h3C08BFAF);
    chk1("t1_data_dok", data_bus.data_ok, 1'b0);
    chk32("t1_data_rdata", data_bus.rdata, 32'd0);
    cyc(); mem_bus.data_ok = 0; mem_bus.rdata = 32'h55AA55AA;
    @(negedge clk);
    chk1("t1_done_busy", busy, 1'b0);
    chk32("t1_rdata_idle", inst_bus.rdata, 32'd0);

    // Simultaneous requests: data wins, inst follows after an IDLE cycle
    cyc();
    inst_bus.req = 1; inst_bus.wr = 0; inst_bus.size = 2; inst_bus.addr = 32'hBFC00004;
    data_bus.req = 1; data_bus.wr = 1; data_bus.size = 2; data_bus.addr = 32'h80001000;
    data_bus.wdata = 32'h12345678;
    cyc(); mem_bus.addr_ok = 1;
    @(negedge clk);
    chk1("t2_owner", owner, 1'b1);
    chk1("t2_mwr", mem_bus.wr, 1'b1);
    chk32("t2_mwdata", mem_bus.wdata, 32'h12345678);
    chk32("t2_maddr", mem_bus.addr, 32'h80001000);
    chk1("t2_data_aok", data_bus.addr_ok, 1'b1);
    chk1("t2_inst_aok", inst_bus.addr_ok, 1'b0);
    cyc(); mem_bus.addr_ok = 0; data_bus.req = 0; mem_bus.data_ok = 1; mem_bus.rdata = 32'hA5A50001;
    @(negedge clk);
    chk1("t2_data_dok", data_bus.data_ok, 1'b1);
    chk32("t2_data_rdata", data_bus.rdata, 32'hA5A50001);
    chk1("t2_inst_dok", inst_bus.data_ok, 1'b0);
    cyc(); mem_bus.data_ok = 0;
    @(negedge clk);
    chk1("t2_idle_between", busy, 1'b0);

    // Inst granted next; slave answers with both oks at once
    cyc(); mem_bus.addr_ok = 1; mem_bus.data_ok = 1; mem_bus.rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk1("t3_owner", owner, 1'b0);
    chk32("t3_maddr", mem_bus.addr, 32'hBFC00004);
    chk1("t3_inst_aok", inst_bus.addr_ok, 1'b1);
    chk1("t3_inst_dok", inst_bus.data_ok, 1'b1);
    chk32("t3_inst_rdata", inst_bus.rdata, 32'hCAFEF00D);

    // Stray slave responses while IDLE
    cyc(); inst_bus.req = 0; mem_bus.rdata = 32'hDEAD0001;
    @(negedge clk);
    chk1("t4_busy", busy, 1'b0);
    chk1("t4_inst_dok", inst_bus.data_ok, 1'b0);
    chk1("t4_data_dok", data_bus.data_ok, 1'b0);
    cyc(); mem_bus.addr_ok = 0;
    @(negedge clk);
    chk1("t4_stay_idle", busy, 1'b0);

    // Reset during DATA
    cyc(); mem_bus.data_ok = 0;
    data_bus.req = 1; data_bus.wr = 0; data_bus.size = 2; data_bus.addr = 32'h00000100;
    cyc(); mem_bus.addr_ok = 1;
    cyc(); mem_bus.addr_ok = 0; data_bus.req = 0;
    @(negedge clk);
    chk1("t5_in_data", busy, 1'b1);
    @(posedge clk); #1; rst_ni = 1'b0; #1;
    chk1("t5_rst_mreq", mem_bus.req, 1'b0);
    chk1("t5_rst_busy", busy, 1'b0);
    cyc(); rst_ni = 1'b1; mem_bus.data_ok = 1; mem_bus.rdata = 32'h00000077;
    @(negedge clk);
    chk1("t5_late_dok", data_bus.data_ok, 1'b0);
    chk1("t5_late_busy", busy, 1'b0);
    cyc(); mem_bus.data_ok = 0;

    // Both masters requesting continuously for four transactions
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    k = 0;
    cyc();
    inst_bus.req = 1; inst_bus.addr = 32'h00000010;
    data_bus.req = 1; data_bus.addr = 32'h00000020;
    mem_bus.addr_ok = 1; mem_bus.data_ok = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_bus.req === 1'b1 && k < 4) begin
        chk1($sformatf("t6_grant%0d", k), owner, exp_order[k]);
        k++;
      end
      cyc();
    end
    chk32("t6_grant_count", 32'(k), 32'd4);
    inst_bus.req = 0; data_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 0;

    // Random traffic, stray responses and occasional resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      seen_i = inst_bus.addr_ok;
      seen_d = data_bus.addr_ok;
      @(posedge clk); #1;
      rst_ni = ($urandom_range(0, 299) != 0);
      mem_bus.addr_ok = 1'($urandom_range(0, 1));
      mem_bus.data_ok = ($urandom_range(0, 9) < 4);
      mem_bus.rdata   = $urandom();
      if (!inst_bus.req || seen_i) begin
        inst_bus.req   = ($urandom_range(0, 2) == 0);
        inst_bus.wr    = 1'($urandom_range(0, 1));
        inst_bus.size  = 2'($urandom_range(0, 3));
        inst_bus.addr  = $urandom();
        inst_bus.wdata = $urandom();
      end
      if (!data_bus.req || seen_d) begin
        data_bus.req   = ($urandom_range(0, 2) == 0);
        data_bus.wr    = 1'($urandom_range(0, 1));
        data_bus.size  = 2'($urandom_range(0, 3));
        data_bus.addr  = $urandom();
        data_bus.wdata = $urandom();
      end
    end
    cyc(); rst_ni = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
